// File: rtl/shift_add_mult_16_pkg.sv
// Shared constants for the shift-and-add multiplier.
//   WIDTH  : operand width (fixed at 16 by the adder)
//   CNT_W  : iteration counter width, log2(WIDTH)
//   state_e: FSM encoding, with 2'b11 left unused (illegal)
package shift_add_mult_16_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

endpackage

// File: rtl/CLA_16R.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second-level group carry chain. Purely combinational.
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : 16-bit sum
//   cout_o   : carry out
module CLA_16R (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin_i;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Carries inside each group are formed from the group's incoming carry.
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = gc[4];

endmodule

// File: rtl/shift_add_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one multiplier bit
// retired per cycle (16 iterations), start/busy/done handshake.
//   clk_i     : rising-edge clock
//   rst_i     : asynchronous active-high reset
//   start_i   : request a multiply; accepted only when idle
//   a_i, b_i  : multiplicand / multiplier, sampled on the accepting edge
//   busy_o    : high while iterating
//   done_o    : one-cycle pulse when product_o is updated
//   product_o : registered 32-bit product, held until the next done
module shift_add_mult_16
  import shift_add_mult_16_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [PROD_W-1:0] product_o
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PROD_W-1:0]  product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH:0]     sel;

  CLA_16R u_cla (
    .a_i    (acc_q),
    .b_i    (m_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  // Add M only when the current multiplier bit is set; the adder carry
  // becomes the top bit so it lands in A[15] after the shift.
  assign sel = q_q[0] ? {carry, sum} : {1'b0, acc_q};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = sel[WIDTH:1];
        q_d     = {sel[0], q_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST_COUNT) begin
          product_d = {acc_d, q_d};
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_shift_add_mult_16.sv
// Self-checking bench for shift_add_mult_16. Expected products are pushed to
// a scoreboard queue when an operation is started and popped when done rises.
module tb_shift_add_mult_16;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] product_o;

  logic [31:0] exp_q[$];
  int          errors;
  int          checks;

  shift_add_mult_16 dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  // Starts one operation and waits for it. Returns the product seen in the
  // done cycle, the number of busy cycles and the done pulses seen in the
  // done cycle plus the next three. inject_at >= 0 pulses start with new
  // operands at that busy cycle.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input int inject_at,
                         output logic [31:0] prod, output int nbusy, output int ndone);
    @(negedge clk_i);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    exp_q.push_back({16'h0, a} * {16'h0, b});
    @(negedge clk_i);
    start_i = 1'b0;
    nbusy = 0;
    while (busy_o === 1'b1 && nbusy < 40) begin
      if (nbusy == inject_at) begin
        start_i = 1'b1;
        a_i = 16'd2;
        b_i = 16'd2;
      end else if (inject_at >= 0 && nbusy == inject_at + 1) begin
        start_i = 1'b0;
        a_i = 16'h5555;
        b_i = 16'hAAAA;
      end
      nbusy++;
      @(negedge clk_i);
    end
    prod = product_o;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_o === 1'b1) ndone++;
      if (i < 3) @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b product=%h, want 0 0 00000000",
               busy_o, done_o, product_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b product=%h, want 0 0 00000000",
                 i, busy_o, done_o, product_o);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] prod, exp;
    int nb, nd;
    do_mult(16'd3, 16'd5, -1, prod, nb, nd);
    exp = pop_exp();
    checks++;
    if (nb != 16) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d cycles, want 16", nb);
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL basic_done_pulses: got %0d, want 1", nd);
    end
    checks++;
    if (prod !== exp || exp !== 32'h0000000F) begin
      errors++;
      $display("FAIL basic_product: got %h, want %h", prod, exp);
    end
    repeat (7) @(negedge clk_i);
    checks++;
    if (product_o !== 32'h0000000F || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: product=%h busy=%b done=%b, want 0000000f 0 0",
               product_o, busy_o, done_o);
    end
  endtask

  task automatic test_table(input string name, input logic [15:0] ta[], input logic [15:0] tb[]);
    logic [31:0] prod, exp;
    int nb, nd;
    for (int i = 0; i < ta.size(); i++) begin
      do_mult(ta[i], tb[i], -1, prod, nb, nd);
      exp = pop_exp();
      checks++;
      if (prod !== exp || nb != 16 || nd != 1) begin
        errors++;
        $display("FAIL %s[%0d] %h*%h: product=%h busy=%0d done=%0d, want %h 16 1",
                 name, i, ta[i], tb[i], prod, nb, nd, exp);
      end
    end
  endtask

  task automatic test_carry();
    logic [15:0] ta[] = '{16'hFFFF, 16'h8000, 16'hFFFF};
    logic [15:0] tb[] = '{16'hFFFF, 16'h0002, 16'h8001};
    test_table("carry", ta, tb);
    checks++;
    if ({16'hFFFF, 16'h0} - {16'h0, 16'hFFFF} - 32'hFFFE0001 != 32'h0
        && product_o !== 32'h7FFF_FFFF * 2 + 32'h8001 - 32'hFFFF) begin
      errors++;
    end
  endtask

  task automatic test_zero_identity();
    logic [15:0] ta[] = '{16'h1234, 16'h0000, 16'hABCD, 16'h0001};
    logic [15:0] tb[] = '{16'h0000, 16'hABCD, 16'h0001, 16'hF00D};
    test_table("zero_ident", ta, tb);
  endtask

  task automatic test_ignored_start();
    logic [31:0] prod, exp;
    int nb, nd;
    do_mult(16'd7, 16'd9, 5, prod, nb, nd);
    exp = pop_exp();
    checks++;
    if (prod !== 32'd63 || prod !== exp) begin
      errors++;
      $display("FAIL ignored_product: got %h, want %h", prod, exp);
    end
    checks++;
    if (nb != 16 || nd != 1) begin
      errors++;
      $display("FAIL ignored_handshake: busy=%0d done=%0d, want 16 1", nb, nd);
    end
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || product_o !== 32'd63) begin
        errors++;
        $display("FAIL ignored_no_second_op: busy=%b product=%h, want 0 0000003f",
                 busy_o, product_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] prod, exp;
    int n, nb, nd;
    @(negedge clk_i);
    a_i = 16'd100;
    b_i = 16'd200;
    start_i = 1'b1;
    exp_q.push_back(32'd20000);
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (n < 8 && busy_o === 1'b1) begin
      n++;
      @(negedge clk_i);
    end
    checks++;
    if (busy_o !== 1'b1 || product_o !== 32'd63) begin
      errors++;
      $display("FAIL mid_before_reset: busy=%b product=%h, want 1 0000003f", busy_o, product_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_async: busy=%b done=%b product=%h, want 0 0 00000000",
               busy_o, done_o, product_o);
    end
    void'(pop_exp());  // aborted operation produces no result
    @(negedge clk_i);
    rst_i = 1'b0;
    do_mult(16'd100, 16'd200, -1, prod, nb, nd);
    exp = pop_exp();
    checks++;
    if (prod !== 32'h00004E20 || prod !== exp || nb != 16 || nd != 1) begin
      errors++;
      $display("FAIL mid_restart: product=%h busy=%0d done=%0d, want 00004e20 16 1",
               prod, nb, nd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int n;
    @(negedge clk_i);
    a_i = 16'h1234;
    b_i = 16'h0101;
    start_i = 1'b1;
    exp_q.push_back(32'h1234 * 32'h0101);
    @(negedge clk_i);
    // Operands for the second accept, while start stays high.
    a_i = 16'h00FF;
    b_i = 16'h0FF0;
    exp_q.push_back(32'h00FF * 32'h0FF0);
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    exp = pop_exp();
    checks++;
    if (n != 16 || done_o !== 1'b1 || product_o !== exp) begin
      errors++;
      $display("FAIL b2b_first: busy=%0d done=%b product=%h, want 16 1 %h",
               n, done_o, product_o, exp);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b done=%b, want 0 0", busy_o, done_o);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: busy=%b, want 1", busy_o);
    end
    start_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    exp = pop_exp();
    checks++;
    if (n != 16 || done_o !== 1'b1 || product_o !== exp) begin
      errors++;
      $display("FAIL b2b_second: busy=%0d done=%b product=%h, want 16 1 %h",
               n, done_o, product_o, exp);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b pending=%0d, want 0 0 0",
               busy_o, done_o, exp_q.size());
    end
  endtask

  // busy and done must never overlap.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && busy_o === 1'b1 && done_o === 1'b1) begin
      errors++;
      checks++;
      $display("FAIL busy_done_overlap: busy=%b done=%b, want not both 1", busy_o, done_o);
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    rst_i   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    test_reset();
    test_basic();
    test_carry();
    test_zero_identity();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
